// File: rtl/rx_beam_pkg.sv
// rx_beam_pkg: shared constants and state encoding for the receive beam sweep controller
package rx_beam_pkg;
  localparam int SIN_WIDTH = 17;
  localparam int HALF_STEPS = 9;
  localparam int NUM_ANGLES = 2 * HALF_STEPS + 1;
  localparam int ANGLE_STEP_DEG = 10;
  localparam int SETTLE_SAMPLES = 32;
  localparam int INTEG_SAMPLES = 256;
  localparam int MIDSCALE = 32768;
  localparam int ENERGY_W = 16 + $clog2(INTEG_SAMPLES);
  localparam int CNT_W = $clog2(INTEG_SAMPLES);
  localparam logic [4:0] HALF_IDX = 5'(HALF_STEPS);
  localparam logic [4:0] LAST_IDX = 5'(NUM_ANGLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
  localparam logic [CNT_W-1:0] INTEG_LAST = CNT_W'(INTEG_SAMPLES - 1);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, INTEG, EVAL, DONE} state_t;
endpackage

// File: rtl/rx_sin_lut.sv
// rx_sin_lut: registered sine ROM, magnitude index m -> round(sin(m*10deg)*2^16)
module rx_sin_lut
  import rx_beam_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 en_in,
  input  logic [3:0]           m_in,
  output logic [SIN_WIDTH-1:0] sin_out
);
  localparam logic [SIN_WIDTH-1:0] ROM [HALF_STEPS+1] = '{
    17'd0, 17'd11380, 17'd22415, 17'd32768, 17'd42126,
    17'd50203, 17'd56756, 17'd61584, 17'd64540, 17'd65536
  };
  logic [SIN_WIDTH-1:0] sin_d, sin_q;
  always_comb sin_d = en_in ? ROM[m_in] : sin_q;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) sin_q <= '0;
    else sin_q <= sin_d;
  assign sin_out = sin_q;
endmodule

// File: rtl/rx_beam_sweep_controller.sv
// rx_beam_sweep_controller: steps the beamformer through all angles and reports the peak-energy angle
module rx_beam_sweep_controller
  import rx_beam_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic                 data_valid_in,
  input  logic [15:0]          aggregated_waveform_in,
  output logic [SIN_WIDTH-1:0] sin_theta,
  output logic                 sign_bit,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [4:0]           best_angle_idx_out,
  output logic [ENERGY_W-1:0]  best_energy_out
);
  state_t state_q, state_d;
  logic [4:0] angle_q, angle_d, best_idx_q, best_idx_d, out_idx_q, out_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ENERGY_W-1:0] acc_q, acc_d, best_e_q, best_e_d, out_e_q, out_e_d;
  logic sign_q, sign_d, busy_q, busy_d, done_q, done_d;
  logic [3:0] m;
  logic [16:0] diff;
  logic [15:0] mag;
  logic last, better;
  assign m = angle_q >= HALF_IDX ? 4'(angle_q - HALF_IDX) : 4'(HALF_IDX - angle_q);
  assign diff = {1'b0, aggregated_waveform_in} - 17'(MIDSCALE);
  assign mag = diff[16] ? 16'(-diff) : diff[15:0];
  assign last = angle_q == LAST_IDX;
  assign better = acc_q > best_e_q;
  rx_sin_lut u_lut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .en_in   (state_q == LOAD),
    .m_in    (m),
    .sin_out (sin_theta)
  );
  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    best_idx_d = best_idx_q;
    best_e_d = best_e_q;
    out_idx_d = out_idx_q;
    out_e_d = out_e_q;
    sign_d = sign_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start_in) begin
        state_d = LOAD;
        angle_d = '0;
        busy_d = 1'b1;
        best_idx_d = '0;
        best_e_d = '0;
      end
      LOAD: begin
        sign_d = angle_q < HALF_IDX;
        cnt_d = '0;
        acc_d = '0;
        state_d = SETTLE;
      end
      SETTLE: if (data_valid_in) begin
        cnt_d = cnt_q == SETTLE_LAST ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == SETTLE_LAST ? INTEG : SETTLE;
      end
      INTEG: if (data_valid_in) begin
        acc_d = acc_q + ENERGY_W'(mag);
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == INTEG_LAST ? EVAL : INTEG;
      end
      EVAL: begin
        best_e_d = better ? acc_q : best_e_q;
        best_idx_d = better ? angle_q : best_idx_q;
        state_d = last ? DONE : LOAD;
        angle_d = last ? angle_q : angle_q + 1'b1;
        done_d = last;
      end
      DONE: begin
        out_idx_d = best_idx_q;
        out_e_d = best_e_q;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      state_q <= IDLE;
      angle_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      best_idx_q <= '0;
      best_e_q <= '0;
      out_idx_q <= '0;
      out_e_q <= '0;
      sign_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      best_idx_q <= best_idx_d;
      best_e_q <= best_e_d;
      out_idx_q <= out_idx_d;
      out_e_q <= out_e_d;
      sign_q <= sign_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign sign_bit = sign_q;
  assign busy_out = busy_q;
  assign done_out = done_q;
  assign best_angle_idx_out = out_idx_q;
  assign best_energy_out = out_e_q;
endmodule

// File: tb/tb_rx_beam_sweep_controller.sv
// tb_rx_beam_sweep_controller: lockstep randomized bench with a behavioural sweep/energy model
module tb_rx_beam_sweep_controller;
  import rx_beam_pkg::*;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic start_in = 1'b0;
  logic data_valid_in = 1'b0;
  logic [15:0] aggregated_waveform_in = '0;
  logic [16:0] sin_theta;
  logic sign_bit, busy_out, done_out;
  logic [4:0] best_angle_idx_out;
  logic [23:0] best_energy_out;
  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  longint exp_e;
  int exp_i;
  rx_beam_sweep_controller dut (
    .clk_in                 (clk_in),
    .rst_in                 (rst_in),
    .start_in               (start_in),
    .data_valid_in          (data_valid_in),
    .aggregated_waveform_in (aggregated_waveform_in),
    .sin_theta              (sin_theta),
    .sign_bit               (sign_bit),
    .busy_out               (busy_out),
    .done_out               (done_out),
    .best_angle_idx_out     (best_angle_idx_out),
    .best_energy_out        (best_energy_out)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) if (done_out) done_cnt <= done_cnt + 1;
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  function automatic int exp_sin(input int a);
    int m;
    real r;
    m = a < HALF_STEPS ? HALF_STEPS - a : a - HALF_STEPS;
    r = $sin(m * ANGLE_STEP_DEG * 3.14159265358979 / 180.0) * 65536.0;
    return $rtoi(r + 0.5);
  endfunction
  function automatic logic [15:0] sample(input int mode, input int a);
    case (mode)
      0: return 16'd32768;
      1: return a == 12 ? 16'd32868 : 16'd32768;
      2: return (a == 4 || a == 14) ? 16'd32868 : 16'd32768;
      default: return 16'($urandom);
    endcase
  endfunction
  task automatic cyc(input logic v, input logic [15:0] d, input logic s);
    data_valid_in = v;
    aggregated_waveform_in = d;
    start_in = s;
    @(negedge clk_in);
  endtask
  task automatic feed(input int gap, input logic [15:0] d, input logic s);
    int g;
    g = gap == 0 ? 0 : int'($urandom_range(gap, 0));
    repeat (g) cyc(1'b0, 16'($urandom), 1'b0);
    cyc(1'b1, d, s);
  endtask
  task automatic check_idle_outputs(input string tag, input logic [4:0] idx, input longint e);
    n_checks++;
    if (busy_out !== 1'b0 || done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_flags: busy=%b done=%b, required busy=0 done=0", tag, busy_out, done_out);
    end
    n_checks++;
    if (best_angle_idx_out !== idx) begin
      n_fail++;
      $display("FAIL %s_idx: got %0d, required %0d", tag, best_angle_idx_out, idx);
    end
    n_checks++;
    if (best_energy_out !== 24'(e)) begin
      n_fail++;
      $display("FAIL %s_energy: got %0d, required %0d", tag, best_energy_out, e);
    end
  endtask
  task automatic sweep(input string tag, input int mode, input int gap, input int restart_at, input int abort_at);
    int d0;
    longint e;
    int dd;
    logic [15:0] d;
    exp_e = 0;
    exp_i = 0;
    d0 = done_cnt;
    cyc(1'b1, 16'($urandom), 1'b1);
    for (int a = 0; a < NUM_ANGLES; a++) begin
      cyc(1'b1, 16'($urandom), 1'b0);
      n_checks++;
      if (sin_theta !== 17'(exp_sin(a)) || sign_bit !== (a < HALF_STEPS)) begin
        n_fail++;
        $display("FAIL %s_steer a=%0d: sin=%0d sign=%b, required sin=%0d sign=%b",
                 tag, a, sin_theta, sign_bit, exp_sin(a), a < HALF_STEPS);
      end
      n_checks++;
      if (busy_out !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_busy a=%0d: got %b, required 1", tag, a, busy_out);
      end
      for (int i = 0; i < SETTLE_SAMPLES; i++) begin
        if (a == abort_at && i == 10) begin
          #2 rst_in = 1'b0;
          #1;
          n_checks++;
          if (sin_theta !== '0 || sign_bit !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0 ||
              best_angle_idx_out !== '0 || best_energy_out !== '0) begin
            n_fail++;
            $display("FAIL %s_async_reset: sin=%0d sign=%b busy=%b done=%b idx=%0d e=%0d, required all 0",
                     tag, sin_theta, sign_bit, busy_out, done_out, best_angle_idx_out, best_energy_out);
          end
          @(negedge clk_in);
          rst_in = 1'b1;
          repeat (40) cyc(1'b1, 16'($urandom), 1'b0);
          n_checks++;
          if (done_cnt != d0 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_abort: done pulses=%0d busy=%b, required 0 and 0", tag, done_cnt - d0, busy_out);
          end
          return;
        end
        feed(gap, 16'($urandom), 1'b0);
      end
      e = 0;
      for (int i = 0; i < INTEG_SAMPLES; i++) begin
        d = sample(mode, a);
        dd = int'(d) - MIDSCALE;
        e += dd < 0 ? -dd : dd;
        feed(gap, d, a == restart_at && i == 100);
      end
      if (e > exp_e) begin
        exp_e = e;
        exp_i = a;
      end
      if (a == NUM_ANGLES - 1) begin
        n_checks++;
        if (done_cnt != d0 || done_out !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_early_done: pulses=%0d done=%b, required 0", tag, done_cnt - d0, done_out);
        end
      end
      cyc(1'b1, 16'($urandom), 1'b0);
    end
    n_checks++;
    if (done_out !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: got %b, required 1", tag, done_out);
    end
    cyc(1'b1, 16'($urandom), 1'b0);
    n_checks++;
    if (done_cnt != d0 + 1) begin
      n_fail++;
      $display("FAIL %s_done_count: got %0d, required 1", tag, done_cnt - d0);
    end
    check_idle_outputs(tag, 5'(exp_i), exp_e);
    repeat (3) cyc(1'b1, 16'($urandom), 1'b0);
    check_idle_outputs({tag, "_hold"}, 5'(exp_i), exp_e);
  endtask
  task automatic test_reset();
    #1;
    check_idle_outputs("reset", 5'd0, 0);
    n_checks++;
    if (sin_theta !== '0 || sign_bit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_steer: sin=%0d sign=%b, required 0 0", sin_theta, sign_bit);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask
  task automatic test_flat();
    sweep("flat", 0, 0, -1, -1);
  endtask
  task automatic test_single_peak();
    sweep("peak", 1, 0, -1, -1);
    n_checks++;
    if (best_angle_idx_out !== 5'd12 || best_energy_out !== 24'd25600) begin
      n_fail++;
      $display("FAIL peak_const: idx=%0d e=%0d, required 12 25600", best_angle_idx_out, best_energy_out);
    end
  endtask
  task automatic test_tie();
    sweep("tie", 2, 0, -1, -1);
    n_checks++;
    if (best_angle_idx_out !== 5'd4) begin
      n_fail++;
      $display("FAIL tie_const: idx=%0d, required 4", best_angle_idx_out);
    end
  endtask
  task automatic test_start_ignored();
    sweep("restart", 3, 0, 5, -1);
  endtask
  task automatic test_reset_abort();
    sweep("abort", 3, 1, -1, 7);
    sweep("after_abort", 3, 2, -1, -1);
  endtask
  initial begin
    test_reset();
    test_flat();
    test_single_peak();
    test_tie();
    test_start_ignored();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rx_beam_sweep_controller.md
Name: rx_beam_sweep_controller

Overview:
- Sequences the receive beamformer through a fixed set of steering angles, one at a time.
- Per angle: drives sin_theta/sign_bit, waits for the delay buffers to refill with samples at the new steering, then integrates the deviation of the aggregated waveform from mid-scale over a fixed sample window.
- After the last angle, reports the angle index with the highest integrated energy.
- Sits between the top-level scan/display logic and the beamformer's steering inputs.

Parameters:
- SIN_WIDTH, 17: width of sin_theta; unsigned magnitude, 1.0 = 2^(SIN_WIDTH-1).
- HALF_STEPS, 9: angle steps from broadside to endfire; NUM_ANGLES = 2*HALF_STEPS+1 = 19.
- ANGLE_STEP_DEG, 10: degrees per step; index k means theta = (k-HALF_STEPS)*ANGLE_STEP_DEG.
- SETTLE_SAMPLES, 32: valid samples discarded after each steering change (≥ beamformer BUFFER_SIZE).
- INTEG_SAMPLES, 256: valid samples integrated per angle; must be a power of 2.
- MIDSCALE, 32768: ADC zero level subtracted from each sample.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- start_in  input  1  single-cycle pulse that begins a sweep; honoured only in IDLE.
- data_valid_in  input  1  aggregated_waveform_in holds a new sample this cycle.
- aggregated_waveform_in  input  16  beamformer output.
- sin_theta  output  SIN_WIDTH  steering sine magnitude to beamformer.
- sign_bit  output  1  1 when theta<0.
- busy_out  output  1  high from the accepted start until done.
- done_out  output  1  one-cycle pulse when a sweep completes.
- best_angle_idx_out  output  5  index 0..NUM_ANGLES-1 of the peak angle.
- best_energy_out  output  16+log2(INTEG_SAMPLES)  energy of the peak angle.

Behaviour:
- Reset (async assert, sync release): state=IDLE; angle_idx=0; all counters and the accumulator 0; sin_theta=0; sign_bit=0; busy_out=0; done_out=0; best_angle_idx_out=0; best_energy_out=0.
- Magnitude index m = |angle_idx - HALF_STEPS|. sign_bit = (angle_idx < HALF_STEPS).
- sin_theta comes from a registered LUT: sin(m*ANGLE_STEP_DEG) rounded to nearest.
- IDLE: on start_in go to LOAD with angle_idx=0. Set busy_out=1, and clear the running best (energy 0, index 0).
- LOAD (1 cycle, covers the LUT latency): the LUT output registers into sin_theta/sign_bit. Clear the settle counter and accumulator. Go to SETTLE.
- SETTLE: count data_valid_in pulses; on the SETTLE_SAMPLES-th go to INTEG. Samples in this state are ignored.
- INTEG: on each data_valid_in, add |aggregated_waveform_in - MIDSCALE| (17-bit signed difference, absolute value, 16-bit result) to the accumulator. The accumulator is sized to never overflow. On the INTEG_SAMPLES-th sample (inclusive) go to EVAL.
- EVAL (1 cycle): if acc > best_energy (strictly greater, so ties keep the lower index), update best. Then:
  - if angle_idx == NUM_ANGLES-1: go to DONE;
  - else: angle_idx++ and go to LOAD.
- DONE (1 cycle): register best into best_angle_idx_out/best_energy_out. done_out=1 for this cycle only. busy_out drops to 0 on the following cycle (back in IDLE).
- Outputs best_* hold their value until the next DONE.
- sin_theta/sign_bit hold the last angle after the sweep ends.
- start_in while busy is ignored (no restart, no queueing).
- data_valid_in in IDLE/LOAD/EVAL/DONE is ignored.
- Reset mid-sweep aborts immediately to reset values; no done_out pulse.
- Cycle count per angle with continuous valid: 1 + SETTLE_SAMPLES + INTEG_SAMPLES + 1.

Decomposition:
- Shared package rx_beam_pkg:
  - state enum {IDLE, LOAD, SETTLE, INTEG, EVAL, DONE};
  - NUM_ANGLES;
  - energy width localparam;
  - MIDSCALE.
- Sub-module rx_sin_lut: HALF_STEPS+1 entry registered ROM, index m -> SIN_WIDTH sine; 1-cycle latency. Entry 0 = 0; entry HALF_STEPS = 65536 at defaults.

Test Plan:
1. Reset, then start with constant 32768 input and valid every cycle -> done_out after 19*290 + 2 cycles; best_energy_out=0; best_angle_idx_out=0 (tie keeps lowest index).
2. Bench returns sample 32768+100 only while angle_idx=12, else 32768 -> best_angle_idx_out=12, best_energy_out=25600. During angle 12: sin_theta=sin(30°)=32768, sign_bit=0.
3. At angle_idx=0 check sign_bit=1, sin_theta=65536. At angle_idx=9 check sin_theta=0, sign_bit=0.
4. Identical samples 32868 at angles 4 and 14 (equal energy), 32768 elsewhere -> best_angle_idx_out=4.
5. Pulse start_in mid-INTEG at angle 5 -> no restart; exactly one done_out; angle sequence unbroken.
6. Deassert rst_in low during SETTLE of angle 7 -> all outputs at reset values asynchronously; no done_out. A new start after release sweeps from angle 0. Valid gated every 100 cycles still yields the correct per-angle sample counts.
